// File: rtl/aryth_host_link.sv
// Host-side driver for the arithmetic wrapper's byte link.
// Sends one {opcode, A, B} request as three strobed bytes, waits for the
// wrapper to raise its ready flag, then collects a two-byte result
// (low byte first) and presents it as a 16-bit word with a done pulse.
module aryth_host_link #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned STRB_GAP    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  opa,
  input  logic [7:0]  opb,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [15:0] result,
  output logic [7:0]  link_data,
  output logic        link_strb,
  input  logic [7:0]  link_rx,
  input  logic        link_rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RX_HI,
    S_DONE
  } state_t;

  // Last legal gap count; when STRB_GAP is 0 the gap branch is never taken.
  localparam logic [3:0]  GAP_LAST = (STRB_GAP == 0) ? 4'd0 : 4'(STRB_GAP - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

  state_t      r_state, w_stateNext;

  logic [2:0]  r_op,      w_op;
  logic [7:0]  r_opa,     w_opa;
  logic [7:0]  r_opb,     w_opb;
  logic [1:0]  r_byteIdx, w_byteIdx;
  logic [1:0]  w_nextIdx;
  logic [3:0]  r_gapCnt,  w_gapCnt;
  logic [15:0] r_toCnt,   w_toCnt;
  logic [7:0]  r_rxLo,    w_rxLo;
  logic        r_busy,    w_busy;
  logic        r_done,    w_done;
  logic        r_err,     w_err;
  logic        r_strb,    w_strb;
  logic [7:0]  r_data,    w_data;
  logic [15:0] r_result,  w_result;

  // Frame byte k of a request: header with opcode, then operand A, then B.
  function automatic logic [7:0] frameByte(input logic [1:0] idx,
                                           input logic [2:0] o,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    case (idx)
      2'd0:    frameByte = {5'b10100, o};
      2'd1:    frameByte = a;
      default: frameByte = b;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state and next-register values; everything holds while ena is low.
  always_comb begin
    w_stateNext = r_state;
    w_op        = r_op;
    w_opa       = r_opa;
    w_opb       = r_opb;
    w_byteIdx   = r_byteIdx;
    w_gapCnt    = r_gapCnt;
    w_toCnt     = r_toCnt;
    w_rxLo      = r_rxLo;
    w_busy      = r_busy;
    w_done      = r_done;
    w_err       = r_err;
    w_strb      = r_strb;
    w_data      = r_data;
    w_result    = r_result;
    w_nextIdx   = r_byteIdx + 2'd1;

    if (ena) begin
      w_done = 1'b0;
      w_err  = 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy may still be high here for the cycle of a timeout pulse;
          // a start arriving in that cycle is ignored like any start while busy.
          w_busy = 1'b0;
          if (start && !r_busy) begin
            w_op        = op;
            w_opa       = opa;
            w_opb       = opb;
            w_busy      = 1'b1;
            w_byteIdx   = 2'd0;
            w_gapCnt    = 4'd0;
            w_toCnt     = 16'd0;
            w_strb      = 1'b1;
            w_data      = frameByte(2'd0, op, opa, opb);
            w_stateNext = S_SEND;
          end
        end

        S_SEND: begin
          if (r_strb && (STRB_GAP != 0)) begin
            w_strb   = 1'b0;
            w_gapCnt = 4'd0;
          end else if (!r_strb && (r_gapCnt != GAP_LAST)) begin
            w_gapCnt = r_gapCnt + 4'd1;
          end else if (r_byteIdx == 2'd2) begin
            w_strb      = 1'b0;
            w_toCnt     = 16'd0;
            w_stateNext = S_WAIT;
          end else begin
            w_byteIdx = w_nextIdx;
            w_data    = frameByte(w_nextIdx, r_op, r_opa, r_opb);
            w_strb    = 1'b1;
          end
        end

        S_WAIT: begin
          if (link_rdy) begin
            w_rxLo      = link_rx;
            w_toCnt     = 16'd0;
            w_stateNext = S_RX_HI;
          end else if (r_toCnt == TO_LAST) begin
            w_toCnt     = 16'd0;
            w_err       = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_toCnt = r_toCnt + 16'd1;
          end
        end

        S_RX_HI: begin
          // The low byte is staged so result only ever changes with done.
          if (link_rdy) begin
            w_result    = {link_rx, r_rxLo};
            w_done      = 1'b1;
            w_toCnt     = 16'd0;
            w_stateNext = S_DONE;
          end else if (r_toCnt == TO_LAST) begin
            w_toCnt     = 16'd0;
            w_err       = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_toCnt = r_toCnt + 16'd1;
          end
        end

        S_DONE: begin
          w_busy      = 1'b0;
          w_stateNext = S_IDLE;
        end

        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 3'd0;
      r_opa     <= 8'd0;
      r_opb     <= 8'd0;
      r_byteIdx <= 2'd0;
      r_gapCnt  <= 4'd0;
      r_toCnt   <= 16'd0;
      r_rxLo    <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_strb    <= 1'b0;
      r_data    <= 8'd0;
      r_result  <= 16'h0000;
    end else begin
      r_op      <= w_op;
      r_opa     <= w_opa;
      r_opb     <= w_opb;
      r_byteIdx <= w_byteIdx;
      r_gapCnt  <= w_gapCnt;
      r_toCnt   <= w_toCnt;
      r_rxLo    <= w_rxLo;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
      r_strb    <= w_strb;
      r_data    <= w_data;
      r_result  <= w_result;
    end
  end

  // The strobe is gated by ena so that a frozen strobe phase is invisible
  // to the wrapper and is re-issued in full once ena returns.
  assign link_strb   = r_strb & ena;
  assign link_data   = r_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign result      = r_result;

endmodule

// File: tb/tb_aryth_host_link.sv
// Bench for aryth_host_link: plays the wrapper side of the byte link and
// checks frames, results, timeouts, ena freezing and asynchronous reset.
module tb_aryth_host_link;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [15:0] result;
  logic [7:0]  link_data;
  logic        link_strb;
  logic [7:0]  link_rx;
  logic        link_rdy;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: bytes the host must put on the link, results
  // it must report, timeouts it must flag, and the word result must show.
  logic [7:0]  expBytes[$];
  logic [15:0] expResults[$];
  int          expErrs = 0;
  logic [15:0] modelResult = 16'h0000;
  logic [7:0]  expByte;

  aryth_host_link #(
    .TIMEOUT_CYC(8),
    .STRB_GAP(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .op(op),
    .opa(opa),
    .opb(opb),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .result(result),
    .link_data(link_data),
    .link_strb(link_strb),
    .link_rx(link_rx),
    .link_rdy(link_rdy)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Wrapper-side arithmetic used to produce the result bytes returned.
  function automatic logic [15:0] arithModel(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd1:    arithModel = 16'(a) + 16'(b);
      3'd3:    arithModel = 16'(a) * 16'(b);
      default: arithModel = {8'h00, a ^ b};
    endcase
  endfunction

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request; returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    expBytes.push_back({5'b10100, o});
    expBytes.push_back(a);
    expBytes.push_back(b);
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    stepCycle(1);
    start = 1'b0;
    op    = ~o;
    opa   = ~a;
    opb   = ~b;
  endtask

  // Wrapper answer: low byte then high byte, rdy held for both cycles.
  task automatic respond(input logic [15:0] value);
    link_rdy = 1'b1;
    link_rx  = value[7:0];
    stepCycle(1);
    link_rx  = value[15:8];
    stepCycle(1);
    link_rdy = 1'b0;
    link_rx  = 8'h00;
  endtask

  // Per-cycle compare of DUT outputs against the transaction model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!ena) checkOutput("strb_while_ena_low", {15'd0, link_strb}, 16'd0);
      if (link_strb) begin
        if (expBytes.size() == 0) begin
          checkOutput("unexpected_strobe", {15'd0, link_strb}, 16'd0);
        end else begin
          expByte = expBytes.pop_front();
          checkOutput("frame_byte", {8'd0, link_data}, {8'd0, expByte});
        end
      end
      if (done) begin
        if (expResults.size() == 0) checkOutput("unexpected_done", {15'd0, done}, 16'd0);
        else modelResult = expResults.pop_front();
      end
      if (err_timeout) begin
        if (expErrs == 0) checkOutput("unexpected_err", {15'd0, err_timeout}, 16'd0);
        else expErrs--;
      end
      checkOutput("result_vs_model", result, modelResult);
    end
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    opa      = 8'h00;
    opb      = 8'h00;
    link_rx  = 8'h00;
    link_rdy = 1'b0;

    #12;
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    checkOutput("rst_err", {15'd0, err_timeout}, 16'd0);
    checkOutput("rst_result", result, 16'h0000);
    checkOutput("rst_link_data", {8'd0, link_data}, 16'h0000);
    checkOutput("rst_link_strb", {15'd0, link_strb}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCycle(2);

    $display("[TB] basic add frame");
    expResults.push_back(arithModel(3'd1, 8'h12, 8'h34));
    applyStimulus(3'd1, 8'h12, 8'h34);
    checkOutput("add_busy_c1", {15'd0, busy}, 16'd1);
    checkOutput("add_strb_c1", {15'd0, link_strb}, 16'd1);
    checkOutput("add_byte0", {8'd0, link_data}, 16'h00A1);
    stepCycle(1);
    checkOutput("add_gap_strb", {15'd0, link_strb}, 16'd0);
    checkOutput("add_gap_data_held", {8'd0, link_data}, 16'h00A1);
    stepCycle(5);
    checkOutput("add_frame_drained", 16'(expBytes.size()), 16'd0);
    respond(arithModel(3'd1, 8'h12, 8'h34));
    checkOutput("add_done", {15'd0, done}, 16'd1);
    checkOutput("add_result", result, 16'h0046);
    checkOutput("add_busy_at_done", {15'd0, busy}, 16'd1);
    stepCycle(1);
    checkOutput("add_busy_after", {15'd0, busy}, 16'd0);
    checkOutput("add_done_after", {15'd0, done}, 16'd0);

    $display("[TB] multiply result, start coinciding with done");
    expResults.push_back(arithModel(3'd3, 8'hFF, 8'hFF));
    applyStimulus(3'd3, 8'hFF, 8'hFF);
    stepCycle(6);
    respond(arithModel(3'd3, 8'hFF, 8'hFF));
    checkOutput("mul_done", {15'd0, done}, 16'd1);
    checkOutput("mul_result", result, 16'hFE01);
    start = 1'b1;
    op    = 3'd5;
    opa   = 8'h77;
    opb   = 8'h88;
    stepCycle(1);
    start = 1'b0;
    checkOutput("mul_busy_after", {15'd0, busy}, 16'd0);
    checkOutput("mul_done_once", {15'd0, done}, 16'd0);
    stepCycle(1);
    checkOutput("start_at_done_ignored", {15'd0, busy}, 16'd0);

    $display("[TB] timeout");
    expErrs = 1;
    applyStimulus(3'd2, 8'h05, 8'h07);
    stepCycle(13);
    checkOutput("to_err_early", {15'd0, err_timeout}, 16'd0);
    checkOutput("to_busy_wait", {15'd0, busy}, 16'd1);
    stepCycle(1);
    checkOutput("to_err_pulse", {15'd0, err_timeout}, 16'd1);
    checkOutput("to_busy_err_cycle", {15'd0, busy}, 16'd1);
    checkOutput("to_no_done", {15'd0, done}, 16'd0);
    checkOutput("to_result_kept", result, 16'hFE01);
    stepCycle(1);
    checkOutput("to_err_cleared", {15'd0, err_timeout}, 16'd0);
    checkOutput("to_busy_cleared", {15'd0, busy}, 16'd0);
    checkOutput("to_err_seen", 16'(expErrs), 16'd0);

    $display("[TB] start while busy");
    expResults.push_back(arithModel(3'd1, 8'h10, 8'h20));
    applyStimulus(3'd1, 8'h10, 8'h20);
    stepCycle(1);
    start = 1'b1;
    op    = 3'd3;
    opa   = 8'hAA;
    opb   = 8'hBB;
    stepCycle(1);
    start = 1'b0;
    stepCycle(4);
    respond(arithModel(3'd1, 8'h10, 8'h20));
    checkOutput("busy_start_done", {15'd0, done}, 16'd1);
    checkOutput("busy_start_result", result, 16'h0030);
    stepCycle(2);
    checkOutput("busy_start_no_second", {15'd0, busy}, 16'd0);

    $display("[TB] ena drop during byte 1");
    expResults.push_back(arithModel(3'd1, 8'h22, 8'h33));
    applyStimulus(3'd1, 8'h22, 8'h33);
    stepCycle(2);
    ena = 1'b0;
    #1;
    checkOutput("ena_strb_forced", {15'd0, link_strb}, 16'd0);
    stepCycle(5);
    ena = 1'b1;
    #1;
    checkOutput("ena_restrobe", {15'd0, link_strb}, 16'd1);
    checkOutput("ena_restrobe_data", {8'd0, link_data}, 16'h0022);
    stepCycle(4);
    checkOutput("ena_frame_drained", 16'(expBytes.size()), 16'd0);
    respond(arithModel(3'd1, 8'h22, 8'h33));
    checkOutput("ena_done", {15'd0, done}, 16'd1);
    checkOutput("ena_result", result, 16'h0055);
    stepCycle(2);

    $display("[TB] reset during WAIT");
    expResults.push_back(arithModel(3'd1, 8'h01, 8'h02));
    applyStimulus(3'd1, 8'h01, 8'h02);
    stepCycle(8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_mid_strb", {15'd0, link_strb}, 16'd0);
    checkOutput("rst_mid_result", result, 16'h0000);
    expResults.delete();
    expBytes.delete();
    modelResult = 16'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCycle(1);
    expResults.push_back(arithModel(3'd1, 8'h40, 8'h02));
    applyStimulus(3'd1, 8'h40, 8'h02);
    stepCycle(6);
    respond(arithModel(3'd1, 8'h40, 8'h02));
    checkOutput("post_rst_done", {15'd0, done}, 16'd1);
    checkOutput("post_rst_result", result, 16'h0042);
    stepCycle(1);
    checkOutput("post_rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("all_results_seen", 16'(expResults.size()), 16'd0);

    stepCycle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
